// File: rtl/imuldiv_mul_arbiter.sv
// Round-robin front end sharing one iterative 32x32 multiplier between two
// requesters; one transaction in flight, response routed back to its issuer.
module imuldiv_mul_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,

  input  logic signed [31:0]  req0_msg_a,
  input  logic signed [31:0]  req0_msg_b,
  input  logic                req0_val,
  output logic                req0_rdy,
  input  logic signed [31:0]  req1_msg_a,
  input  logic signed [31:0]  req1_msg_b,
  input  logic                req1_val,
  output logic                req1_rdy,

  output logic signed [63:0]  resp0_msg_result,
  output logic                resp0_val,
  input  logic                resp0_rdy,
  output logic signed [63:0]  resp1_msg_result,
  output logic                resp1_val,
  input  logic                resp1_rdy,

  output logic signed [31:0]  mulreq_msg_a,
  output logic signed [31:0]  mulreq_msg_b,
  output logic                mulreq_val,
  input  logic                mulreq_rdy,
  input  logic signed [63:0]  mulresp_msg_result,
  input  logic                mulresp_val,
  output logic                mulresp_rdy,

  output logic [CNT_W-1:0]    done_cnt0,
  output logic [CNT_W-1:0]    done_cnt1
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   done_cnt0_q, done_cnt0_d;
  logic [CNT_W-1:0]   done_cnt1_q, done_cnt1_d;

  logic               in_idle;
  logic               in_wait;
  logic               gnt_any;
  logic               gnt_sel;
  logic               owner_rdy;
  logic               req_fire;
  logic               resp_fire;

  // Grant: a lone requester wins; on a tie the prio port wins.
  always_comb begin
    in_idle = (state_q == ST_IDLE) && !reset;
    in_wait = (state_q == ST_WAIT) && !reset;
    gnt_any = req0_val | req1_val;
    gnt_sel = (req0_val && req1_val) ? prio_q : req1_val;
  end

  // Outputs are gated by reset so every val/rdy is low while reset is held.
  always_comb begin
    mulreq_msg_a     = gnt_sel ? req1_msg_a : req0_msg_a;
    mulreq_msg_b     = gnt_sel ? req1_msg_b : req0_msg_b;
    mulreq_val       = in_idle & gnt_any;
    req0_rdy         = in_idle & gnt_any & ~gnt_sel & mulreq_rdy;
    req1_rdy         = in_idle & gnt_any &  gnt_sel & mulreq_rdy;

    owner_rdy        = owner_q ? resp1_rdy : resp0_rdy;
    mulresp_rdy      = in_wait & owner_rdy;
    resp0_val        = in_wait & ~owner_q & mulresp_val;
    resp1_val        = in_wait &  owner_q & mulresp_val;
    resp0_msg_result = mulresp_msg_result;
    resp1_msg_result = mulresp_msg_result;

    done_cnt0        = done_cnt0_q;
    done_cnt1        = done_cnt1_q;
  end

  always_comb begin
    req_fire    = mulreq_val & mulreq_rdy;
    resp_fire   = mulresp_val & mulresp_rdy;
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    done_cnt0_d = done_cnt0_q;
    done_cnt1_d = done_cnt1_q;
    if (req_fire) begin
      state_d = ST_WAIT;
      owner_d = gnt_sel;
      prio_d  = ~gnt_sel;
    end
    if (resp_fire) begin
      state_d = ST_IDLE;
      if (owner_q) done_cnt1_d = done_cnt1_q + CNT_W'(1);
      else         done_cnt0_d = done_cnt0_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      done_cnt0_q <= '0;
      done_cnt1_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      done_cnt0_q <= done_cnt0_d;
      done_cnt1_q <= done_cnt1_d;
    end
  end

endmodule
